// File: rtl/uart_pkg.sv
// Shared UART constants, baud-mode encodings and the TX arbiter state type.
package uart_pkg;

    localparam int B4800  = 2604;
    localparam int B9600  = 1302;
    localparam int B14_4K = 868;
    localparam int B19_2K = 651;

    localparam logic [1:0] MODE_4800  = 2'b00;
    localparam logic [1:0] MODE_9600  = 2'b01;
    localparam logic [1:0] MODE_14_4K = 2'b10;
    localparam logic [1:0] MODE_19_2K = 2'b11;

    localparam int OVS = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HOLD = 2'b01,
        WAIT = 2'b10
    } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester bundle plus the UART TX bundle; the arbiter uses the master side.
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 4
) ();
    logic [N_REQ-1:0]   req;
    logic [8*N_REQ-1:0] req_data;
    logic [2*N_REQ-1:0] req_mode;
    logic [N_REQ-1:0]   gnt;
    logic [N_REQ-1:0]   done;
    logic [N_REQ-1:0]   err;
    logic               busy;
    logic               uart_tx_en;
    logic [1:0]         uart_tx_mode;
    logic [7:0]         uart_tx_data;
    logic               uart_tx_done;

    modport master (
        input  req, req_data, req_mode, uart_tx_done,
        output gnt, done, err, busy, uart_tx_en, uart_tx_mode, uart_tx_data
    );

    modport slave (
        output req, req_data, req_mode, uart_tx_done,
        input  gnt, done, err, busy, uart_tx_en, uart_tx_mode, uart_tx_data
    );
endinterface

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic          valid
);
    logic [PW:0] idx_s;
    logic        found_s;

    // Walk the requests from ptr with wrap-around, keeping only the first hit.
    always_comb begin
        gnt     = '0;
        found_s = 1'b0;
        idx_s   = '0;
        for (int k = 0; k < N; k++) begin
            idx_s = {1'b0, ptr} + (PW+1)'(k);
            if (idx_s >= (PW+1)'(N)) begin
                idx_s = idx_s - (PW+1)'(N);
            end else begin
                idx_s = idx_s;
            end
            if (req[idx_s[PW-1:0]] && !found_s) begin
                gnt[idx_s[PW-1:0]] = 1'b1;
                found_s            = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    assign valid = found_s;
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin owner of the single UART transmitter: latches one byte per grant,
// holds TX_EN for a fixed window, then reports completion or timeout.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int EN_HOLD = OVS * B19_2K,
    parameter int TIMEOUT = 262143
) (
    input  logic              sclk,
    input  logic              rst_n,
    uart_tx_arbiter_if.master bus
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int HW = $clog2(EN_HOLD);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [HW-1:0] HOLD_LAST = HW'(EN_HOLD - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [PW-1:0] PTR_LAST  = PW'(N_REQ - 1);

    arb_state_t       state_r, state_nxt_s;
    logic [PW-1:0]    ptr_r, ptr_nxt_s, owner_r, owner_nxt_s, gnt_idx_s;
    logic [HW-1:0]    hold_cnt_r, hold_nxt_s;
    logic [TW-1:0]    to_cnt_r, to_nxt_s;
    logic             done_seen_r, seen_nxt_s, done_q_r, done_rise_s, done_any_s;
    logic [N_REQ-1:0] gnt_r, gnt_nxt_s, done_r, done_nxt_s, err_r, err_nxt_s;
    logic [N_REQ-1:0] arb_gnt_s;
    logic             arb_valid_s, busy_r, tx_en_r, en_nxt_s;
    logic [1:0]       tx_mode_r, mode_nxt_s;
    logic [7:0]       tx_data_r, data_nxt_s;

    rr_arbiter #(.N(N_REQ), .PW(PW)) u_rr (
        .req   (bus.req),
        .ptr   (ptr_r),
        .gnt   (arb_gnt_s),
        .valid (arb_valid_s)
    );

    assign done_rise_s = bus.uart_tx_done & ~done_q_r;
    assign done_any_s  = done_rise_s | done_seen_r;

    // One-hot grant to binary index.
    always_comb begin
        gnt_idx_s = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (arb_gnt_s[j]) begin
                gnt_idx_s = PW'(j);
            end else begin
                gnt_idx_s = gnt_idx_s;
            end
        end
    end

    // Next-state and next-output logic; pulse outputs default low every cycle.
    always_comb begin
        state_nxt_s = state_r;
        ptr_nxt_s   = ptr_r;
        owner_nxt_s = owner_r;
        hold_nxt_s  = hold_cnt_r;
        to_nxt_s    = to_cnt_r;
        seen_nxt_s  = done_seen_r;
        gnt_nxt_s   = '0;
        done_nxt_s  = '0;
        err_nxt_s   = '0;
        en_nxt_s    = tx_en_r;
        mode_nxt_s  = tx_mode_r;
        data_nxt_s  = tx_data_r;
        case (state_r)
            IDLE: begin
                if (arb_valid_s) begin
                    gnt_nxt_s   = arb_gnt_s;
                    data_nxt_s  = bus.req_data[{gnt_idx_s, 3'b000} +: 8];
                    mode_nxt_s  = bus.req_mode[{gnt_idx_s, 1'b0} +: 2];
                    en_nxt_s    = 1'b1;
                    hold_nxt_s  = '0;
                    to_nxt_s    = '0;
                    seen_nxt_s  = 1'b0;
                    owner_nxt_s = gnt_idx_s;
                    ptr_nxt_s   = (gnt_idx_s == PTR_LAST) ? '0 : gnt_idx_s + PW'(1);
                    state_nxt_s = HOLD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            HOLD: begin
                if ((to_cnt_r == TO_LAST) && !done_any_s) begin
                    err_nxt_s[owner_r] = 1'b1;
                    en_nxt_s           = 1'b0;
                    state_nxt_s        = IDLE;
                end else begin
                    to_nxt_s = (to_cnt_r == TO_LAST) ? to_cnt_r : to_cnt_r + TW'(1);
                    // An early TX_DONE is remembered and reported once WAIT is reached.
                    seen_nxt_s = done_seen_r | done_rise_s;
                    if (hold_cnt_r == HOLD_LAST) begin
                        en_nxt_s    = 1'b0;
                        state_nxt_s = WAIT;
                    end else begin
                        hold_nxt_s = hold_cnt_r + HW'(1);
                    end
                end
            end
            WAIT: begin
                if (done_any_s) begin
                    done_nxt_s[owner_r] = 1'b1;
                    seen_nxt_s          = 1'b0;
                    state_nxt_s         = IDLE;
                end else if (to_cnt_r == TO_LAST) begin
                    err_nxt_s[owner_r] = 1'b1;
                    en_nxt_s           = 1'b0;
                    state_nxt_s        = IDLE;
                end else begin
                    to_nxt_s = to_cnt_r + TW'(1);
                end
            end
            default: begin
                en_nxt_s    = 1'b0;
                seen_nxt_s  = 1'b0;
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, counters, latched byte and registered outputs.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            ptr_r       <= '0;
            owner_r     <= '0;
            hold_cnt_r  <= '0;
            to_cnt_r    <= '0;
            done_seen_r <= 1'b0;
            done_q_r    <= 1'b0;
            gnt_r       <= '0;
            done_r      <= '0;
            err_r       <= '0;
            busy_r      <= 1'b0;
            tx_en_r     <= 1'b0;
            tx_mode_r   <= 2'b00;
            tx_data_r   <= 8'h00;
        end else begin
            state_r     <= state_nxt_s;
            ptr_r       <= ptr_nxt_s;
            owner_r     <= owner_nxt_s;
            hold_cnt_r  <= hold_nxt_s;
            to_cnt_r    <= to_nxt_s;
            done_seen_r <= seen_nxt_s;
            done_q_r    <= bus.uart_tx_done;
            gnt_r       <= gnt_nxt_s;
            done_r      <= done_nxt_s;
            err_r       <= err_nxt_s;
            busy_r      <= (state_nxt_s != IDLE);
            tx_en_r     <= en_nxt_s;
            tx_mode_r   <= mode_nxt_s;
            tx_data_r   <= data_nxt_s;
        end
    end

    assign bus.gnt          = gnt_r;
    assign bus.done         = done_r;
    assign bus.err          = err_r;
    assign bus.busy         = busy_r;
    assign bus.uart_tx_en   = tx_en_r;
    assign bus.uart_tx_mode = tx_mode_r;
    assign bus.uart_tx_data = tx_data_r;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a UART stub and a grant/completion scoreboard.
module tb_uart_tx_arbiter;
    localparam int N_REQ    = 4;
    localparam int EN_HOLD  = 16;
    localparam int TIMEOUT  = 400;
    localparam int TX_DELAY = 200;

    typedef struct {
        logic [3:0] oh;
        logic [7:0] data;
        logic [1:0] mode;
        int         lat;
        bit         is_err;
    } exp_t;

    logic sclk = 1'b0;
    logic rst_n;

    uart_tx_arbiter_if #(.N_REQ(N_REQ)) bus ();

    uart_tx_arbiter #(.N_REQ(N_REQ), .EN_HOLD(EN_HOLD), .TIMEOUT(TIMEOUT)) dut (
        .sclk  (sclk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 sclk = ~sclk;

    int   n_pass = 0;
    int   n_total = 0;
    int   cyc = 0;
    int   n_gnt = 0;
    int   grant_cyc = 0;
    int   last_cmpl_cyc = -1;
    int   en_cnt = 0;
    int   stub_cnt = 0;
    int   stub_delay = TX_DELAY;
    bit   cur_valid = 1'b0;
    bit   stub_active = 1'b0;
    bit   stub_en_prev = 1'b0;
    bit   mon_en_prev = 1'b0;
    exp_t cur;
    exp_t exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic exp_t mk(input int i, input int lat, input bit is_err);
        exp_t e;
        e.oh     = 4'(1 << i);
        e.data   = bus.req_data[8*i +: 8];
        e.mode   = bus.req_mode[2*i +: 2];
        e.lat    = lat;
        e.is_err = is_err;
        return e;
    endfunction

    // Scoreboard: completions are checked first so a same-cycle regrant is caught.
    task automatic monitor();
        if (bus.done !== 4'b0000 || bus.err !== 4'b0000) begin
            if (!cur_valid) begin
                chk("cmpl_unexpected", 32'({bus.done, bus.err}), 32'h0);
            end else begin
                chk(cur.is_err ? "err_vec" : "done_vec",
                    32'(cur.is_err ? bus.err : bus.done), 32'(cur.oh));
                chk(cur.is_err ? "done_during_err" : "err_during_done",
                    32'(cur.is_err ? bus.done : bus.err), 32'h0);
                chk("cmpl_latency", 32'(cyc - grant_cyc), 32'(cur.lat));
                chk("busy_at_cmpl", 32'(bus.busy), 32'h0);
                chk("tx_en_at_cmpl", 32'(bus.uart_tx_en), 32'h0);
                chk("tx_data_stable", 32'(bus.uart_tx_data), 32'(cur.data));
                cur_valid     = 1'b0;
                last_cmpl_cyc = cyc;
            end
        end
        if (bus.gnt !== 4'b0000) begin
            if (exp_q.size() == 0) begin
                chk("gnt_unexpected", 32'(bus.gnt), 32'h0);
            end else begin
                chk("gnt_while_owned", 32'(cur_valid), 32'h0);
                chk("idle_gap", 32'(cyc > last_cmpl_cyc), 32'h1);
                cur = exp_q.pop_front();
                chk("gnt_vec", 32'(bus.gnt), 32'(cur.oh));
                chk("tx_data", 32'(bus.uart_tx_data), 32'(cur.data));
                chk("tx_mode", 32'(bus.uart_tx_mode), 32'(cur.mode));
                chk("busy_at_gnt", 32'(bus.busy), 32'h1);
                cur_valid = 1'b1;
                grant_cyc = cyc;
                n_gnt++;
            end
        end
        if (bus.uart_tx_en === 1'b1) begin
            en_cnt++;
        end else if (mon_en_prev) begin
            chk("tx_en_width", 32'(en_cnt), 32'(EN_HOLD));
            en_cnt = 0;
        end
        mon_en_prev = (bus.uart_tx_en === 1'b1);
    endtask

    // UART stub: TX_DONE is a one-cycle pulse starting stub_delay cycles after TX_EN rises.
    task automatic stub();
        if (stub_active) stub_cnt++;
        if (bus.uart_tx_en === 1'b1 && !stub_en_prev && stub_delay > 0) begin
            stub_active = 1'b1;
            stub_cnt    = 0;
        end
        bus.uart_tx_done = stub_active && (stub_cnt == stub_delay);
        if (stub_active && stub_cnt > stub_delay) stub_active = 1'b0;
        stub_en_prev = (bus.uart_tx_en === 1'b1);
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge sclk);
            cyc++;
            monitor();
            stub();
        end
    endtask

    task automatic do_reset();
        rst_n            = 1'b0;
        bus.req          = 4'b0000;
        bus.uart_tx_done = 1'b0;
        stub_active      = 1'b0;
        stub_en_prev     = 1'b0;
        mon_en_prev      = 1'b0;
        cur_valid        = 1'b0;
        en_cnt           = 0;
        n_gnt            = 0;
        last_cmpl_cyc    = -1;
        exp_q.delete();
        step(3);
        rst_n = 1'b1;
    endtask

    task automatic wait_grants(input int target, input int budget);
        int b = 0;
        while (n_gnt < target && b < budget) begin
            step(1);
            b++;
        end
        chk("grant_count", 32'(n_gnt), 32'(target));
    endtask

    task automatic wait_drain(input int budget);
        int b = 0;
        while ((exp_q.size() != 0 || cur_valid) && b < budget) begin
            step(1);
            b++;
        end
        chk("drained", 32'(exp_q.size()) + 32'(cur_valid), 32'h0);
        step(2);
        chk("busy_after", 32'(bus.busy), 32'h0);
    endtask

    initial begin
        bus.req_data = 32'h0;
        bus.req_mode = 8'h00;
        do_reset();
        chk("rst_gnt", 32'(bus.gnt), 32'h0);
        chk("rst_done", 32'(bus.done), 32'h0);
        chk("rst_err", 32'(bus.err), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_tx_en", 32'(bus.uart_tx_en), 32'h0);
        chk("rst_tx_mode", 32'(bus.uart_tx_mode), 32'h0);
        chk("rst_tx_data", 32'(bus.uart_tx_data), 32'h0);

        // Single request
        bus.req_data = 32'h000000A1;
        bus.req_mode = 8'b0000_0011;
        exp_q.push_back(mk(0, TX_DELAY + 1, 1'b0));
        bus.req = 4'b0001;
        step(1);
        chk("single_gnt_next_cycle", 32'(bus.gnt), 32'h1);
        chk("single_tx_en", 32'(bus.uart_tx_en), 32'h1);
        bus.req = 4'b0000;
        wait_drain(600);

        // Round-robin with all requests held
        do_reset();
        bus.req_data = 32'h40302010;
        bus.req_mode = 8'b00_01_10_11;
        exp_q.push_back(mk(0, TX_DELAY + 1, 1'b0));
        exp_q.push_back(mk(1, TX_DELAY + 1, 1'b0));
        exp_q.push_back(mk(2, TX_DELAY + 1, 1'b0));
        exp_q.push_back(mk(3, TX_DELAY + 1, 1'b0));
        exp_q.push_back(mk(0, TX_DELAY + 1, 1'b0));
        bus.req = 4'b1111;
        wait_grants(5, 1500);
        bus.req = 4'b0000;
        wait_drain(600);

        // Pointer wrap: last grant 3, then 1001 twice
        do_reset();
        exp_q.push_back(mk(3, TX_DELAY + 1, 1'b0));
        bus.req = 4'b1000;
        wait_grants(1, 50);
        bus.req = 4'b0000;
        wait_drain(600);
        exp_q.push_back(mk(0, TX_DELAY + 1, 1'b0));
        exp_q.push_back(mk(3, TX_DELAY + 1, 1'b0));
        bus.req = 4'b1001;
        wait_grants(3, 600);
        bus.req = 4'b0000;
        wait_drain(600);

        // Timeout with a silent UART, then pointer must sit at 3
        do_reset();
        stub_delay = 0;
        exp_q.push_back(mk(2, TIMEOUT, 1'b1));
        bus.req = 4'b0100;
        wait_grants(1, 50);
        bus.req = 4'b0000;
        wait_drain(800);
        stub_delay = TX_DELAY;
        exp_q.push_back(mk(3, TX_DELAY + 1, 1'b0));
        bus.req = 4'b1111;
        wait_grants(2, 50);
        bus.req = 4'b0000;
        wait_drain(600);

        // Reset while waiting for TX_DONE
        do_reset();
        bus.req_data = 32'h44332211;
        exp_q.push_back(mk(1, TX_DELAY + 1, 1'b0));
        bus.req = 4'b0010;
        wait_grants(1, 50);
        bus.req = 4'b0000;
        step(40);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_tx_en", 32'(bus.uart_tx_en), 32'h0);
        chk("midrst_busy", 32'(bus.busy), 32'h0);
        chk("midrst_gnt", 32'(bus.gnt), 32'h0);
        chk("midrst_done", 32'(bus.done), 32'h0);
        chk("midrst_err", 32'(bus.err), 32'h0);
        do_reset();
        exp_q.push_back(mk(1, TX_DELAY + 1, 1'b0));
        bus.req = 4'b0110;
        wait_grants(1, 50);
        bus.req = 4'b0000;
        wait_drain(600);

        // TX_DONE arriving during the hold window
        do_reset();
        stub_delay = 10;
        exp_q.push_back(mk(0, EN_HOLD + 1, 1'b0));
        bus.req = 4'b0001;
        wait_grants(1, 50);
        bus.req = 4'b0000;
        wait_drain(200);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
